// File: rtl/ram_arb_pkg.sv
// Shared widths and controller state encoding for the two-port RAM arbiter.
package ram_arb_pkg;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 8;
    localparam int NUM_WORDS = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/ram_rr_arb.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the pointer,
// and the pointer moves to the loser after every granted command.
module ram_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_valid_0,
    input  logic i_valid_1,
    output logic o_grant_0,
    output logic o_grant_1
);
    logic r_rr_ptr;

    always_comb begin
        o_grant_0 = 1'b0;
        o_grant_1 = 1'b0;
        if (i_enable) begin
            if (i_valid_0 && i_valid_1) begin
                o_grant_0 = !r_rr_ptr;
                o_grant_1 = r_rr_ptr;
            end else begin
                o_grant_0 = i_valid_0;
                o_grant_1 = i_valid_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (o_grant_0) begin
            r_rr_ptr <= 1'b1;
        end else if (o_grant_1) begin
            r_rr_ptr <= 1'b0;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Controller in front of an external RAM8_8: fills every word with INIT_VAL,
// then serves two requesters one command per cycle through a round-robin arbiter.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic              req_we_0,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              ram_wr_enb,
    output logic              ram_rd_enb,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);
    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_next_cnt;
    logic              w_serve;
    logic              w_grant_0;
    logic              w_grant_1;
    logic              r_rsp_valid_0;
    logic              r_rsp_valid_1;

    assign w_serve = (r_state == ST_RUN) && !clr;

    ram_rr_arb u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_enable  (w_serve),
        .i_valid_0 (req_valid_0),
        .i_valid_1 (req_valid_1),
        .o_grant_0 (w_grant_0),
        .o_grant_1 (w_grant_1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (clr) begin
                    w_next_cnt = '0;
                end else begin
                    w_next_cnt = r_cnt + 3'd1;
                    if (r_cnt == ADDR_W'(NUM_WORDS - 1)) begin
                        w_next_state = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (clr) begin
                    w_next_state = ST_INIT;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = ST_INIT;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Only one requester is ever granted, so write and read enables never split across requesters.
    always_comb begin
        ram_wr_enb  = 1'b0;
        ram_wr_addr = r_cnt;
        ram_data_in = INIT_VAL;
        ram_rd_enb  = 1'b0;
        ram_rd_addr = '0;
        if (r_state == ST_INIT) begin
            ram_wr_enb = 1'b1;
        end else if (w_grant_0) begin
            if (req_we_0) begin
                ram_wr_enb  = 1'b1;
                ram_wr_addr = req_addr_0;
                ram_data_in = req_wdata_0;
            end else begin
                ram_rd_enb  = 1'b1;
                ram_rd_addr = req_addr_0;
            end
        end else if (w_grant_1) begin
            if (req_we_1) begin
                ram_wr_enb  = 1'b1;
                ram_wr_addr = req_addr_1;
                ram_data_in = req_wdata_1;
            end else begin
                ram_rd_enb  = 1'b1;
                ram_rd_addr = req_addr_1;
            end
        end
    end

    // Response follows the RAM's one-cycle read latency, independent of any clr that arrives meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid_0 <= 1'b0;
            r_rsp_valid_1 <= 1'b0;
        end else begin
            r_rsp_valid_0 <= w_grant_0 && !req_we_0;
            r_rsp_valid_1 <= w_grant_1 && !req_we_1;
        end
    end

    assign req_ready_0 = w_grant_0;
    assign req_ready_1 = w_grant_1;
    assign rsp_valid_0 = r_rsp_valid_0;
    assign rsp_valid_1 = r_rsp_valid_1;
    assign rsp_rdata   = ram_data_out;
    assign init_done   = (r_state == ST_RUN);
endmodule
